// File: rtl/acc_pkg.sv
// Shared accelerator definitions: default bus widths and the requester tags
// used to steer memory read responses.
package acc_pkg;

    localparam int ADDR_W_DFLT = 32;
    localparam int DATA_W_DFLT = 32;

    typedef enum logic {
        TAG_WEIGHT = 1'b0,
        TAG_FMAP   = 1'b1
    } tag_e;

endpackage

// File: rtl/arb_tag_fifo.sv
// In-order FIFO of requester tags, one entry per outstanding memory read.
// The occupancy count covers issued-but-unanswered reads.
module arb_tag_fifo
    import acc_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  tag_e                     tag_i,
    input  logic                     pop_i,
    output tag_e                     head_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   cnt_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

    tag_e             mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   cnt_q;

    // NOTE: the storage array has no reset; entries are only read behind a
    // non-zero count, so resetting the pointers and count is sufficient.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= tag_i;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == DEPTH_C);
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/mem_rd_arb.sv
// Round-robin arbiter sharing the memory read port between the weight and
// fmap BIUs; responses are steered back in order using a tag FIFO.
module mem_rd_arb
    import acc_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DFLT,
    parameter int DATA_W = DATA_W_DFLT,
    parameter int OUTSTD = 8
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic [ADDR_W-1:0] weight_biu2arb_addr,
    input  logic              weight_biu2arb_vld,
    output logic              weight_biu2arb_rdy,
    output logic [ADDR_W-1:0] arb2weight_biu_addr,
    output logic [DATA_W-1:0] arb2weight_biu_data,
    output logic              arb2weight_biu_vld,
    input  logic              arb2weight_biu_rdy,

    input  logic [ADDR_W-1:0] fmap_biu2arb_addr,
    input  logic              fmap_biu2arb_vld,
    output logic              fmap_biu2arb_rdy,
    output logic [ADDR_W-1:0] arb2fmap_biu_addr,
    output logic [DATA_W-1:0] arb2fmap_biu_data,
    output logic              arb2fmap_biu_vld,
    input  logic              arb2fmap_biu_rdy,

    output logic [ADDR_W-1:0] arb2mem_addr,
    output logic              arb2mem_vld,
    input  logic              arb2mem_rdy,
    input  logic [ADDR_W-1:0] mem2arb_addr,
    input  logic [DATA_W-1:0] mem2arb_data,
    input  logic              mem2arb_vld,
    output logic              mem2arb_rdy,

    output logic              arb_idle
);

    localparam int CNT_W = $clog2(OUTSTD) + 1;

    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_vld_q, mem_vld_d;
    tag_e              last_q, last_d;

    tag_e              winner;
    logic              slot_free, can_issue, grant, pop;
    tag_e              head;
    logic              empty, full;
    logic [CNT_W-1:0]  cnt;

    // NOTE: give every always_comb output a default first so no path
    // through the block leaves it unassigned and infers a latch.
    always_comb begin
        winner = TAG_WEIGHT;
        if (weight_biu2arb_vld && fmap_biu2arb_vld) begin
            winner = (last_q == TAG_WEIGHT) ? TAG_FMAP : TAG_WEIGHT;
        end else if (fmap_biu2arb_vld) begin
            winner = TAG_FMAP;
        end
    end

    // The count is registered, so a response popped this cycle frees space next cycle.
    assign slot_free = !mem_vld_q || arb2mem_rdy;
    assign can_issue = slot_free && !full;
    assign grant     = can_issue && (weight_biu2arb_vld || fmap_biu2arb_vld);

    assign weight_biu2arb_rdy = can_issue && weight_biu2arb_vld && (winner == TAG_WEIGHT);
    assign fmap_biu2arb_rdy   = can_issue && fmap_biu2arb_vld && (winner == TAG_FMAP);

    always_comb begin
        mem_addr_d = mem_addr_q;
        mem_vld_d  = mem_vld_q;
        last_d     = last_q;
        if (grant) begin
            mem_addr_d = (winner == TAG_FMAP) ? fmap_biu2arb_addr : weight_biu2arb_addr;
            mem_vld_d  = 1'b1;
            last_d     = winner;
        end else if (arb2mem_rdy) begin
            mem_vld_d  = 1'b0;
        end
    end

    // Pointer resets to fmap so the weight requester wins the first conflict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr_q <= '0;
            mem_vld_q  <= 1'b0;
            last_q     <= TAG_FMAP;
        end else begin
            mem_addr_q <= mem_addr_d;
            mem_vld_q  <= mem_vld_d;
            last_q     <= last_d;
        end
    end

    arb_tag_fifo #(
        .DEPTH (OUTSTD)
    ) u_tag_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (grant),
        .tag_i   (winner),
        .pop_i   (pop),
        .head_o  (head),
        .empty_o (empty),
        .full_o  (full),
        .cnt_o   (cnt)
    );

    assign mem2arb_rdy = !empty && ((head == TAG_FMAP) ? arb2fmap_biu_rdy : arb2weight_biu_rdy);
    assign pop         = mem2arb_vld && mem2arb_rdy;

    assign arb2weight_biu_vld  = mem2arb_vld && !empty && (head == TAG_WEIGHT);
    assign arb2fmap_biu_vld    = mem2arb_vld && !empty && (head == TAG_FMAP);
    assign arb2weight_biu_addr = mem2arb_addr;
    assign arb2weight_biu_data = mem2arb_data;
    assign arb2fmap_biu_addr   = mem2arb_addr;
    assign arb2fmap_biu_data   = mem2arb_data;

    assign arb2mem_addr = mem_addr_q;
    assign arb2mem_vld  = mem_vld_q;
    assign arb_idle     = !mem_vld_q && (cnt == '0);

endmodule
